// File: rtl/parking_pkg.sv
// ============================================================================
// Module : parking_pkg
// Brief  : Shared constants for the parking duration timer slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package parking_pkg;

    localparam logic [1:0] ST_OK             = 2'b00;
    localparam logic [1:0] ST_ALREADY_ACTIVE = 2'b01;
    localparam logic [1:0] ST_NOT_ACTIVE     = 2'b10;
    localparam logic [1:0] ST_BAD_SLOT       = 2'b11;

    localparam logic OP_START = 1'b0;
    localparam logic OP_STOP  = 1'b1;

    localparam logic [5:0] SEC_MAX = 6'd59;

    localparam int             FSM_W    = 1;
    localparam logic [FSM_W-1:0] FSM_IDLE = 1'b0;
    localparam logic [FSM_W-1:0] FSM_RESP = 1'b1;

endpackage : parking_pkg

`default_nettype wire

// File: rtl/parking_duration_timer_if.sv
// ============================================================================
// Module : parking_duration_timer_if
// Brief  : Command/response handshake bundle between controller and timer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface parking_duration_timer_if #(
    parameter int SLOT_W = 2,
    parameter int MIN_W  = 10
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [SLOT_W-1:0] cmd_slot;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [SLOT_W-1:0] rsp_slot;
    logic [MIN_W-1:0]  rsp_minutes;
    logic [5:0]        rsp_seconds;
    logic [1:0]        rsp_status;

    modport master (
        output cmd_valid, cmd_op, cmd_slot, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_slot, rsp_minutes, rsp_seconds, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_slot, rsp_ready,
        output cmd_ready, rsp_valid, rsp_slot, rsp_minutes, rsp_seconds, rsp_status
    );

endinterface : parking_duration_timer_if

`default_nettype wire

// File: rtl/tick_edge_detect.sv
// ============================================================================
// Module : tick_edge_detect
// Brief  : Rising-edge pulse from a clk-domain level signal.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_level,
    output logic      o_pulse
);

    logic r_level_q;

    // Resetting to 1 suppresses a false edge when the level is already high at release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_q <= RESET_VAL;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_pulse = i_level & ~r_level_q;

endmodule : tick_edge_detect

`default_nettype wire

// File: rtl/parking_duration_timer.sv
// ============================================================================
// Module : parking_duration_timer
// Brief  : Per-slot mm:ss parking timers driven by 1 Hz ticks, start/stop cmds.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module parking_duration_timer
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2,
    parameter int MIN_W     = 10
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 tick_1Hz,
    parking_duration_timer_if.slave   bus,
    output logic [NUM_SLOTS-1:0]      active
);

    localparam logic [MIN_W-1:0] c_MIN_MAX = '1;

    logic                 w_sec_pulse;
    logic                 w_accept;
    logic                 w_slot_ok;
    logic                 w_start_go;
    logic                 w_stop_go;
    logic [MIN_W-1:0]     w_cur_min;
    logic [5:0]           w_cur_sec;
    logic                 w_cur_act;
    logic [SLOT_W-1:0]    w_rsp_slot;
    logic [MIN_W-1:0]     w_rsp_min;
    logic [5:0]           w_rsp_sec;
    logic [1:0]           w_rsp_status;

    logic [MIN_W-1:0]     w_min_arr [NUM_SLOTS];
    logic [5:0]           w_sec_arr [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_active;

    logic [FSM_W-1:0]     r_state;
    logic                 r_cmd_ready;
    logic                 r_rsp_valid;
    logic [SLOT_W-1:0]    r_rsp_slot;
    logic [MIN_W-1:0]     r_rsp_min;
    logic [5:0]           r_rsp_sec;
    logic [1:0]           r_rsp_status;

    tick_edge_detect #(
        .RESET_VAL (1'b1)
    ) u_tick_edge (
        .clk     (clk),
        .rst     (reset),
        .i_level (tick_1Hz),
        .o_pulse (w_sec_pulse)
    );

    assign w_accept  = (r_state == FSM_IDLE) & bus.cmd_valid & r_cmd_ready;
    assign w_slot_ok = ({1'b0, bus.cmd_slot} < (SLOT_W+1)'(NUM_SLOTS));

    always_comb begin
        w_cur_min = '0;
        w_cur_sec = '0;
        w_cur_act = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.cmd_slot == SLOT_W'(i)) begin
                w_cur_min = w_min_arr[i];
                w_cur_sec = w_sec_arr[i];
                w_cur_act = w_active[i];
            end
        end
    end

    assign w_start_go = w_accept & (bus.cmd_op == OP_START) & w_slot_ok & ~w_cur_act;
    assign w_stop_go  = w_accept & (bus.cmd_op == OP_STOP)  & w_slot_ok &  w_cur_act;

    // Commands on a slot take priority over a coincident second pulse for that slot
    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
            logic             w_hit;
            logic             r_act;
            logic [MIN_W-1:0] r_min;
            logic [5:0]       r_sec;

            assign w_hit = (bus.cmd_slot == SLOT_W'(i));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_act <= 1'b0;
                    r_min <= '0;
                    r_sec <= '0;
                end else if (w_start_go && w_hit) begin
                    r_act <= 1'b1;
                    r_min <= '0;
                    r_sec <= '0;
                end else if (w_stop_go && w_hit) begin
                    r_act <= 1'b0;
                end else if (r_act && w_sec_pulse) begin
                    if (r_sec == SEC_MAX) begin
                        if (r_min != c_MIN_MAX) begin
                            r_sec <= '0;
                            r_min <= r_min + 1'b1;
                        end
                    end else begin
                        r_sec <= r_sec + 1'b1;
                    end
                end
            end

            assign w_active[i]  = r_act;
            assign w_min_arr[i] = r_min;
            assign w_sec_arr[i] = r_sec;
        end
    endgenerate

    always_comb begin
        w_rsp_slot   = bus.cmd_slot;
        w_rsp_min    = '0;
        w_rsp_sec    = '0;
        w_rsp_status = ST_OK;
        if (!w_slot_ok) begin
            w_rsp_slot   = '0;
            w_rsp_status = ST_BAD_SLOT;
        end else if (bus.cmd_op == OP_START) begin
            if (w_cur_act) begin
                w_rsp_status = ST_ALREADY_ACTIVE;
                w_rsp_min    = w_cur_min;
                w_rsp_sec    = w_cur_sec;
            end
        end else begin
            if (w_cur_act) begin
                w_rsp_min = w_cur_min;
                w_rsp_sec = w_cur_sec;
            end else begin
                w_rsp_status = ST_NOT_ACTIVE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= FSM_IDLE;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_slot   <= '0;
            r_rsp_min    <= '0;
            r_rsp_sec    <= '0;
            r_rsp_status <= ST_OK;
        end else begin
            case (r_state)
                FSM_IDLE: begin
                    if (w_accept) begin
                        r_state      <= FSM_RESP;
                        r_cmd_ready  <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_slot   <= w_rsp_slot;
                        r_rsp_min    <= w_rsp_min;
                        r_rsp_sec    <= w_rsp_sec;
                        r_rsp_status <= w_rsp_status;
                    end else begin
                        r_cmd_ready  <= 1'b1;
                    end
                end
                FSM_RESP: begin
                    if (r_rsp_valid && bus.rsp_ready) begin
                        r_state     <= FSM_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= FSM_IDLE;
                    r_cmd_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_slot    = r_rsp_slot;
    assign bus.rsp_minutes = r_rsp_min;
    assign bus.rsp_seconds = r_rsp_sec;
    assign bus.rsp_status  = r_rsp_status;
    assign active          = w_active;

endmodule : parking_duration_timer

`default_nettype wire

// File: doc/parking_duration_timer.md
# parking_duration_timer

Per-slot parking duration timer that consumes the 1 Hz square-wave output of the system clock divider and turns its rising edges into second ticks. It holds one minutes:seconds counter per parking slot and serves start/stop commands from the parking controller over a valid/ready handshake. Each command returns one response carrying the elapsed duration and a status code. It sits between the clock divider and the fee/display logic.

## Interface
- NUM_SLOTS, 4, number of independently timed slots
- SLOT_W, 2, slot index width; must satisfy 2^SLOT_W >= NUM_SLOTS
- MIN_W, 10, minutes counter width; counter saturates at 2^MIN_W-1

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- tick_1Hz  in  1  divider 1 Hz level signal, registered in the clk domain; each rising edge is one second
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command; registered
- cmd_op  in  1  0 = START, 1 = STOP
- cmd_slot  in  SLOT_W  target slot
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_slot  out  SLOT_W  slot of the response
- rsp_minutes  out  MIN_W  elapsed minutes
- rsp_seconds  out  6  elapsed seconds, 0..59
- rsp_status  out  2  00 OK, 01 ALREADY_ACTIVE, 10 NOT_ACTIVE, 11 BAD_SLOT
- active  out  NUM_SLOTS  bit i = 1 while slot i is timing

## Operation
- **Edge detect:** tick_q <= tick_1Hz; sec_pulse = tick_1Hz & ~tick_q. tick_q resets to 1, so a high tick_1Hz at reset release produces no pulse.
- **Counting on sec_pulse, per slot i with active[i]=1:**
  - seconds 59 -> 0 and minutes +1; otherwise seconds +1.
  - At minutes = 2^MIN_W-1 and seconds = 59 the counter holds; it does not wrap.
- **Command FSM:** states IDLE and RESP. A command is accepted when cmd_valid & cmd_ready; acceptance moves IDLE -> RESP. In RESP the block leaves the state when rsp_valid & rsp_ready, returning to IDLE.
- **START on slot s:**
  - s >= NUM_SLOTS: BAD_SLOT, all fields 0.
  - active[s]=1: ALREADY_ACTIVE, returns the current count, slot unaffected.
  - Otherwise: clear the counter, set active[s], respond OK with 0:00.
- **STOP on slot s:**
  - s >= NUM_SLOTS: BAD_SLOT.
  - active[s]=0: NOT_ACTIVE, 0:00.
  - Otherwise: respond OK with the counter value, clear active[s]; the counter keeps its value until the next START.
- **Response fields** are registered at acceptance and held stable while rsp_valid=1.
- **Ticks continue** to advance all active slots in both IDLE and RESP.

## Timing
- **Reset values:** cmd_ready=0, rsp_valid=0, rsp_slot=0, rsp_minutes=0, rsp_seconds=0, rsp_status=00, active=0. All counters are 0 and the state is IDLE.
- cmd_ready rises on the first clk edge after reset deasserts.
- **Latency:** command accepted at edge N -> rsp_valid=1 and cmd_ready=0 from N+1. Response handshake at edge M -> rsp_valid=0 and cmd_ready=1 from M+1. Maximum throughput is one command per 2 cycles.
- **Same-cycle sec_pulse and START of slot s:** the counter is cleared and the pulse is not counted for s.
- **Same-cycle sec_pulse and STOP of slot s:** the response reports the pre-increment value; the pulse is discarded for s.
- **Same-cycle sec_pulse and ALREADY_ACTIVE:** the response reports the pre-increment value; the slot still increments.
- **Reset mid-operation:** a pending response is dropped and all slots become inactive immediately (asynchronous).

## Structure
- **Shared package `parking_pkg`:** status codes (ST_OK, ST_ALREADY_ACTIVE, ST_NOT_ACTIVE, ST_BAD_SLOT), op codes (OP_START, OP_STOP), SEC_MAX=59, FSM state encoding.
- **Sub-module `tick_edge_detect`:** one flop plus an AND gate, with a reset-to-1 option. It is reusable for the 2 Hz, 4 Hz and 1-minute divider outputs.
- **Counter storage:** per-slot counters as register arrays generated over NUM_SLOTS.

## Test plan
- Reset with tick_1Hz high, release, hold it high 10 cycles -> no slot counts, active=0, cmd_ready=1 one cycle after release.
- START slot 1, apply 125 tick rising edges, STOP slot 1 -> rsp OK, minutes=2, seconds=5, active[1]=0.
- STOP slot 2 while idle -> NOT_ACTIVE, 0:00. START slot 0 twice -> second response ALREADY_ACTIVE with the current count. With NUM_SLOTS=3, START slot 3 -> BAD_SLOT.
- Issue STOP slot 0 on the same cycle as a tick edge with count 0:59 -> rsp 0:59. Issue START slot 0 on a tick edge -> count 0:00 one cycle later.
- Hold rsp_ready=0 for 20 cycles while ticks arrive -> rsp fields stable, cmd_ready=0, other active slots keep counting.
- MIN_W=2: run 240 ticks -> counter holds at 3:59; STOP returns 3:59.
